// File: rtl/booth4_mul_seq.sv
`default_nettype none
// ============================================================================
// Module   : booth4_mul_seq
// Brief    : Sequential radix-4 Booth multiplier. Retires two multiplier bits
//            per cycle, signed or unsigned per operation, start/rdy handshake.
// Revision : 1.0 - initial release
// ============================================================================
module booth4_mul_seq #(
  parameter int WIDTH = 8  // operand width, even and >= 4
) (
  input  logic               clk,
  input  logic               reset,        // asynchronous, active low
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               rdy,
  output logic [2*WIDTH-1:0] p
);

  // Operands carry two extra bits so the top Booth digit of an unsigned
  // operand always sees a zero sign, and the accumulator has headroom for
  // the +/-2A partial products shifted to the highest digit position.
  localparam int EW     = WIDTH + 2;
  localparam int AW     = 2*WIDTH + 4;
  localparam int N_ITER = WIDTH/2 + 1;
  localparam int CW     = $clog2(N_ITER + 1);
  localparam logic [CW-1:0] LAST_DIGIT = CW'(N_ITER - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // control strobes decoded by the FSM
  logic load;
  logic step;
  logic finish;

  // latched operation context
  logic [EW-1:0] a_ext;
  logic [EW-1:0] b_ext;
  logic          mode;

  // datapath state
  logic [AW-1:0] acc;
  logic [CW-1:0] cnt;

  // datapath combinational signals
  logic [EW-1:0] a_in_ext;
  logic [EW-1:0] b_in_ext;
  logic [EW:0]   b_cat;
  logic [2:0]    digit;
  logic [AW-1:0] a_acc;
  logic [AW-1:0] pp_base;
  logic [AW-1:0] pp;
  logic [AW-1:0] acc_nxt;

  // Extend incoming operands to EW bits according to the requested mode.
  always_comb begin
    a_in_ext = {{2{signed_mode & a[WIDTH-1]}}, a};
    b_in_ext = {{2{signed_mode & b[WIDTH-1]}}, b};
  end

  // Select the current Booth digit and form the shifted partial product.
  always_comb begin
    // appended zero provides the implicit b[-1] of digit 0
    b_cat = {b_ext, 1'b0};
    digit = b_cat[{cnt, 1'b0} +: 3];
    // in unsigned mode a_ext MSB is already zero; the mode gate keeps the
    // extension tied to how the operand was latched
    a_acc = {{(AW-EW){mode & a_ext[EW-1]}}, a_ext};
    unique case (digit)
      3'b001, 3'b010: pp_base = a_acc;
      3'b011:         pp_base = a_acc << 1;
      3'b100:         pp_base = (~(a_acc << 1)) + AW'(1);
      3'b101, 3'b110: pp_base = (~a_acc) + AW'(1);
      default:        pp_base = '0;  // 000 and 111
    endcase
    pp      = pp_base << {cnt, 1'b0};
    acc_nxt = acc + pp;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state and control strobe decode.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        // start is deliberately ignored here: the operation in flight owns
        // the latched operands until it completes
        step = 1'b1;
        if (cnt == LAST_DIGIT) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath: operand capture, accumulation and result/handshake registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_ext <= '0;
      b_ext <= '0;
      mode  <= 1'b0;
      acc   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      rdy   <= 1'b0;
      p     <= '0;
    end else if (load) begin
      a_ext <= a_in_ext;
      b_ext <= b_in_ext;
      mode  <= signed_mode;
      acc   <= '0;
      cnt   <= '0;
      busy  <= 1'b1;
      rdy   <= 1'b0;
      p     <= '0;
    end else if (step) begin
      acc <= acc_nxt;
      cnt <= cnt + CW'(1);
      if (finish) begin
        // truncation to 2*WIDTH bits is exact in both modes
        p    <= acc_nxt[2*WIDTH-1:0];
        rdy  <= 1'b1;
        busy <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_booth4_mul_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_booth4_mul_seq
// Brief    : Directed and back-to-back random bench for booth4_mul_seq at
//            WIDTH=8 and WIDTH=16.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_booth4_mul_seq;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;

  logic        start8 = 1'b0;
  logic        mode8  = 1'b0;
  logic [7:0]  a8     = '0;
  logic [7:0]  b8     = '0;
  logic        busy8;
  logic        rdy8;
  logic [15:0] p8;

  logic        start16 = 1'b0;
  logic        mode16  = 1'b0;
  logic [15:0] a16     = '0;
  logic [15:0] b16     = '0;
  logic        busy16;
  logic        rdy16;
  logic [31:0] p16;

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;

  always #5 clk = ~clk;

  booth4_mul_seq #(.WIDTH(8)) dut8 (
    .clk         (clk),
    .reset       (reset),
    .start       (start8),
    .signed_mode (mode8),
    .a           (a8),
    .b           (b8),
    .busy        (busy8),
    .rdy         (rdy8),
    .p           (p8)
  );

  booth4_mul_seq #(.WIDTH(16)) dut16 (
    .clk         (clk),
    .reset       (reset),
    .start       (start16),
    .signed_mode (mode16),
    .a           (a16),
    .b           (b16),
    .busy        (busy16),
    .rdy         (rdy16),
    .p           (p16)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // busy and rdy must never be high together
  always @(negedge clk) begin
    if (mon_en) begin
      check_val("excl8", {63'b0, busy8 & rdy8}, 64'd0);
      check_val("excl16", {63'b0, busy16 & rdy16}, 64'd0);
    end
  end

  // independent reference: plain multiply at 16 bits
  function automatic logic [15:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic m);
    logic signed [15:0] sx;
    logic signed [15:0] sy;
    logic signed [15:0] sp;
    logic        [15:0] ux;
    logic        [15:0] uy;
    logic        [15:0] up;
    sx = $signed(x);
    sy = $signed(y);
    sp = sx * sy;
    ux = {8'b0, x};
    uy = {8'b0, y};
    up = ux * uy;
    return m ? sp : up;
  endfunction

  // launch on the next edge; caller sits #1 after an edge
  task automatic launch8(input logic [7:0] x, input logic [7:0] y, input logic m);
    a8 = x; b8 = y; mode8 = m; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
  endtask

  task automatic launch16(input logic [15:0] x, input logic [15:0] y, input logic m);
    a16 = x; b16 = y; mode16 = m; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
  endtask

  // edges counted after the start edge until rdy, bounded
  task automatic wait_rdy8(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!rdy8 && lat < 40);
  endtask

  task automatic wait_rdy16(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!rdy16 && lat < 40);
  endtask

  initial begin
    int lat;
    logic [7:0] cur_a;
    logic [7:0] cur_b;
    logic       cur_m;

    // reset state
    #1;
    check_val("rst_p8", {48'b0, p8}, 64'd0);
    check_val("rst_rdy8", {63'b0, rdy8}, 64'd0);
    check_val("rst_busy8", {63'b0, busy8}, 64'd0);
    check_val("rst_p16", {32'b0, p16}, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    reset  = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // signed -128 x -128
    launch8(8'h80, 8'h80, 1'b1);
    check_val("busy_after_start", {63'b0, busy8}, 64'd1);
    wait_rdy8(lat);
    check_val("lat_m128sq", 64'(lat), 64'd5);
    check_val("p_m128sq", {48'b0, p8}, 64'h4000);
    repeat (3) @(posedge clk);
    #1;
    check_val("hold_p", {48'b0, p8}, 64'h4000);
    check_val("hold_rdy", {63'b0, rdy8}, 64'd1);

    // new start from DONE clears p and rdy on the start edge
    launch8(8'hFF, 8'hFF, 1'b0);
    check_val("clr_p", {48'b0, p8}, 64'd0);
    check_val("clr_rdy", {63'b0, rdy8}, 64'd0);
    wait_rdy8(lat);
    check_val("p_ffff_u", {48'b0, p8}, 64'hFE01);
    launch8(8'hFF, 8'hFF, 1'b1);
    wait_rdy8(lat);
    check_val("p_ffff_s", {48'b0, p8}, 64'h0001);

    // -3 x 5 with a start pulse during RUN that must be ignored
    launch8(8'hFD, 8'h05, 1'b1);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin
        start8 = 1'b1; a8 = 8'h11; b8 = 8'h22; mode8 = 1'b0;
      end else if (lat == 2) begin
        start8 = 1'b0;
      end
    end while (!rdy8 && lat < 40);
    check_val("lat_m3x5", 64'(lat), 64'd5);
    check_val("p_m3x5", {48'b0, p8}, 64'hFFF1);

    // asynchronous reset two cycles into RUN
    launch8(8'h12, 8'h34, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check_val("arst_p", {48'b0, p8}, 64'd0);
    check_val("arst_rdy", {63'b0, rdy8}, 64'd0);
    check_val("arst_busy", {63'b0, busy8}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check_val("idle_busy", {63'b0, busy8}, 64'd0);
    check_val("idle_rdy", {63'b0, rdy8}, 64'd0);
    launch8(8'd7, 8'd9, 1'b1);
    wait_rdy8(lat);
    check_val("lat_7x9", 64'(lat), 64'd5);
    check_val("p_7x9", {48'b0, p8}, 64'h003F);

    // WIDTH=16
    launch16(16'h8000, 16'h7FFF, 1'b1);
    wait_rdy16(lat);
    check_val("lat16", 64'(lat), 64'd9);
    check_val("p16_s", {32'b0, p16}, 64'hC0008000);
    launch16(16'hFFFF, 16'hFFFF, 1'b0);
    wait_rdy16(lat);
    check_val("p16_u", {32'b0, p16}, 64'hFFFE0001);

    // back-to-back with start held high in DONE
    a8 = 8'($urandom); b8 = 8'($urandom); mode8 = 1'($urandom);
    start8 = 1'b1;
    for (int j = 0; j < 1000; j++) begin
      cur_a = a8; cur_b = b8; cur_m = mode8;
      @(posedge clk); #1;
      check_val("b2b_busy", {63'b0, busy8}, 64'd1);
      check_val("b2b_pclr", {48'b0, p8}, 64'd0);
      // bus changes while running must not disturb the operation
      a8 = 8'($urandom); b8 = 8'($urandom); mode8 = 1'($urandom);
      wait_rdy8(lat);
      check_val("b2b_lat", 64'(lat), 64'd5);
      check_val("b2b_p", {48'b0, p8}, {48'b0, ref8(cur_a, cur_b, cur_m)});
    end
    start8 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
